// File: rtl/ds18b20_pkg.sv
// Shared definitions for the DS18B20 temperature formatter.
// FSM state encodings, range limit constants, conversion length and the
// double-dabble nibble adjust helper.
package ds18b20_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    // Largest positive code (+125.0 C) and largest negative magnitude (55.0 C).
    localparam logic [15:0] TEMP_MAX_CODE = 16'h07D0;
    localparam logic [15:0] TEMP_MIN_MAG  = 16'h0370;

    // Integer part is 7 bits wide, so one shift per bit.
    localparam int CONV_BITS = 7;

    // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift.
    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/ds18b20_bcd_serial.sv
// Serial double-dabble converter: 7-bit binary to three BCD digits,
// one bit per clock, MSB first. 'start' loads the operand; 'done' is high
// during the final shift cycle, and 'bcd' holds the result from the next
// cycle until the following start.
module ds18b20_bcd_serial
    import ds18b20_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [6:0]  sh;
    logic [2:0]  cnt;
    logic        active;
    logic [11:0] bcd_adj;

    // Correct every digit before it is shifted.
    always_comb begin
        bcd_adj = {dd_adj(bcd[11:8]), dd_adj(bcd[7:4]), dd_adj(bcd[3:0])};
    end

    // Load on start, then shift one binary bit into the BCD register per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= '0;
            cnt    <= '0;
            active <= 1'b0;
            bcd    <= '0;
        end else if (start) begin
            sh     <= bin;
            cnt    <= 3'(CONV_BITS);
            active <= 1'b1;
            bcd    <= '0;
        end else if (active) begin
            bcd    <= 12'({bcd_adj, sh[6]});
            sh     <= {sh[5:0], 1'b0};
            cnt    <= cnt - 3'd1;
            if (cnt == 3'd1) begin
                active <= 1'b0;
            end
        end
    end

    // Final shift is happening this cycle.
    always_comb begin
        done = active && (cnt == 3'd1);
    end

endmodule

// File: rtl/ds18b20_temp_fmt.sv
// DS18B20 temperature formatter: captures each 16-bit code from the
// one-wire driver and produces sign, BCD hundreds/tens/ones, a truncated
// tenths digit, a signed integer and a range-error flag.
// Optional over-temperature alarm with hysteresis: define TEMP_ALARM_EN.
module ds18b20_temp_fmt
    import ds18b20_pkg::*;
#(
    parameter logic signed [7:0] ALARM_HI = 8'sd50,
    parameter logic signed [7:0] ALARM_LO = 8'sd45
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [15:0]       raw_data,
    input  logic              raw_valid,
    output logic              temp_sign,
    output logic [3:0]        temp_bcd_h,
    output logic [3:0]        temp_bcd_t,
    output logic [3:0]        temp_bcd_o,
    output logic [3:0]        temp_frac,
    output logic signed [7:0] temp_int,
    output logic              fmt_valid,
    output logic              busy,
    output logic              range_err
`ifdef TEMP_ALARM_EN
    ,
    output logic              alarm
`endif
);

    // raw_valid synchronizer, edge-detect stage and arming logic.
    // 'armed' only sets once a real low sample has been seen, so a level
    // already high when reset is released never looks like a new edge.
    logic sync1, sync2, sync3, sync1_real, armed, rise;

    state_t state, state_nxt;

    logic [15:0]       cap;
    logic [15:0]       mag;
    logic [6:0]        int7_c;
    logic [3:0]        frac_c;
    logic              rerr_c;

    logic              sign_r;
    logic [6:0]        int7_r;
    logic [3:0]        frac_r;
    logic              rerr_r;
    logic signed [7:0] int_new;

    logic              bcd_start;
    logic              bcd_done;
    logic [11:0]       bcd;

    // Synchronize raw_valid into clk_in and track whether an edge may be trusted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            sync1_real <= 1'b0;
            armed      <= 1'b0;
        end else begin
            sync1      <= raw_valid;
            sync2      <= sync1;
            sync3      <= sync2;
            sync1_real <= 1'b1;
            armed      <= armed | (sync1_real & ~sync1);
        end
    end

    // Single-cycle rising-edge pulse.
    always_comb begin
        rise = sync2 & ~sync3 & armed;
    end

    // Magnitude, integer part, tenths digit and range check of the captured code.
    always_comb begin
        mag    = cap[15] ? (~cap + 16'd1) : cap;
        int7_c = mag[10:4];
        frac_c = 4'(({4'd0, mag[3:0]} * 8'd10) >> 4);
        rerr_c = (mag[15:11] != 5'd0) |
                 (!cap[15] && (mag > TEMP_MAX_CODE)) |
                 ( cap[15] && (mag > TEMP_MIN_MAG));
    end

    // Signed integer that a valid update will publish.
    always_comb begin
        int_new = sign_r ? $signed(8'd0 - {1'b0, int7_r}) : $signed({1'b0, int7_r});
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and FSM-derived controls.
    always_comb begin
        state_nxt = state;
        bcd_start = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = ABS;
                end
            end
            ABS: begin
                busy      = 1'b1;
                bcd_start = 1'b1;
                state_nxt = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (bcd_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    ds18b20_bcd_serial u_bcd (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .start (bcd_start),
        .bin   (int7_c),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // Capture, intermediate results and published outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cap        <= '0;
            sign_r     <= 1'b0;
            int7_r     <= '0;
            frac_r     <= '0;
            rerr_r     <= 1'b0;
            temp_sign  <= 1'b0;
            temp_bcd_h <= '0;
            temp_bcd_t <= '0;
            temp_bcd_o <= '0;
            temp_frac  <= '0;
            temp_int   <= '0;
            fmt_valid  <= 1'b0;
            range_err  <= 1'b0;
`ifdef TEMP_ALARM_EN
            alarm      <= 1'b0;
`endif
        end else begin
            fmt_valid <= (state == DONE);
            if (state == IDLE && rise) begin
                cap <= raw_data;
            end
            if (state == ABS) begin
                sign_r <= cap[15];
                int7_r <= int7_c;
                frac_r <= frac_c;
                rerr_r <= rerr_c;
            end
            if (state == DONE) begin
                if (rerr_r) begin
                    // Out-of-range code: flag it, keep the last good reading.
                    range_err <= 1'b1;
                end else begin
                    range_err  <= 1'b0;
                    temp_sign  <= sign_r;
                    temp_bcd_h <= bcd[11:8];
                    temp_bcd_t <= bcd[7:4];
                    temp_bcd_o <= bcd[3:0];
                    temp_frac  <= frac_r;
                    temp_int   <= int_new;
`ifdef TEMP_ALARM_EN
                    if (int_new >= ALARM_HI) begin
                        alarm <= 1'b1;
                    end else if (int_new < ALARM_LO) begin
                        alarm <= 1'b0;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ds18b20_temp_fmt.sv
// Self-checking bench for ds18b20_temp_fmt: a vector table of codes with
// hand-derived results, a scoreboard queue fed at stimulus time and drained
// on fmt_valid, plus hand sequences for busy-drop and mid-conversion reset.
// Build with TEMP_ALARM_EN defined to also check the alarm.
module tb_ds18b20_temp_fmt;

    localparam int W = 27;

    logic              clk;
    logic              rst_n;
    logic [15:0]       raw_data;
    logic              raw_valid;
    logic              temp_sign;
    logic [3:0]        temp_bcd_h, temp_bcd_t, temp_bcd_o, temp_frac;
    logic signed [7:0] temp_int;
    logic              fmt_valid, busy, range_err;
    logic              alarm_bit;
`ifdef TEMP_ALARM_EN
    logic              alarm;
    assign alarm_bit = alarm;
`else
    assign alarm_bit = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int fmt_cnt = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [15:0]       raw;
        logic              sign;
        logic [3:0]        h, t, o, f;
        logic signed [7:0] ti;
        logic              rerr;
        logic              alm;
    } vec_t;

    vec_t tbl[15];

    ds18b20_temp_fmt dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .raw_data   (raw_data),
        .raw_valid  (raw_valid),
        .temp_sign  (temp_sign),
        .temp_bcd_h (temp_bcd_h),
        .temp_bcd_t (temp_bcd_t),
        .temp_bcd_o (temp_bcd_o),
        .temp_frac  (temp_frac),
        .temp_int   (temp_int),
        .fmt_valid  (fmt_valid),
        .busy       (busy),
        .range_err  (range_err)
`ifdef TEMP_ALARM_EN
        ,
        .alarm      (alarm)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input logic alm, input logic sign,
                                          input logic [3:0] h, input logic [3:0] t,
                                          input logic [3:0] o, input logic [3:0] f,
                                          input logic [7:0] ti, input logic rerr);
`ifdef TEMP_ALARM_EN
        return {alm, sign, h, t, o, f, ti, rerr};
`else
        return {1'b0, sign, h, t, o, f, ti, rerr};
`endif
    endfunction

    function automatic logic [W-1:0] pack_vec(input vec_t v);
        return pack(v.alm, v.sign, v.h, v.t, v.o, v.f, v.ti, v.rerr);
    endfunction

    function automatic logic [W-1:0] actual();
        return {alarm_bit, temp_sign, temp_bcd_h, temp_bcd_t, temp_bcd_o,
                temp_frac, temp_int, range_err};
    endfunction

    // Scoreboard: every fmt_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && fmt_valid) begin
            fmt_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fmt_valid: got outputs %h, expected no pulse", actual());
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (actual() !== e) begin
                    errors++;
                    $display("FAIL outputs: got %h expected %h", actual(), e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive one code, queue its expectation, check busy and the 12-cycle latency.
    task automatic send(input logic [15:0] raw, input logic [W-1:0] e);
        int lat;
        @(negedge clk);
        raw_data  = raw;
        raw_valid = 1'b1;
        exp_q.push_back(e);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 3) check("busy_rise", 32'(busy), 32'd1);
            if (i == 5) raw_valid = 1'b0;
            if (fmt_valid) lat = i;
        end
        check("latency", 32'(lat), 32'd12);
        check("busy_fall", 32'(busy), 32'd0);
        idle(4);
    endtask

    initial begin
        int base;
        tbl[0]  = '{16'h0191, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0,   8'sd25, 1'b0, 1'b0};
        tbl[1]  = '{16'hFF5E, 1'b1, 4'd0, 4'd1, 4'd0, 4'd1,  -8'sd10, 1'b0, 1'b0};
        tbl[2]  = '{16'h07D0, 1'b0, 4'd1, 4'd2, 4'd5, 4'd0,  8'sd125, 1'b0, 1'b1};
        tbl[3]  = '{16'h0800, 1'b0, 4'd1, 4'd2, 4'd5, 4'd0,  8'sd125, 1'b1, 1'b1};
        tbl[4]  = '{16'hFC90, 1'b1, 4'd0, 4'd5, 4'd5, 4'd0,  -8'sd55, 1'b0, 1'b0};
        tbl[5]  = '{16'hFC8F, 1'b1, 4'd0, 4'd5, 4'd5, 4'd0,  -8'sd55, 1'b1, 1'b0};
        tbl[6]  = '{16'hFFF8, 1'b1, 4'd0, 4'd0, 4'd0, 4'd5,    8'sd0, 1'b0, 1'b0};
        tbl[7]  = '{16'h0000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0,    8'sd0, 1'b0, 1'b0};
        tbl[8]  = '{16'h0320, 1'b0, 4'd0, 4'd5, 4'd0, 4'd0,   8'sd50, 1'b0, 1'b1};
        tbl[9]  = '{16'h02E0, 1'b0, 4'd0, 4'd4, 4'd6, 4'd0,   8'sd46, 1'b0, 1'b1};
        tbl[10] = '{16'h02C0, 1'b0, 4'd0, 4'd4, 4'd4, 4'd0,   8'sd44, 1'b0, 1'b0};
        tbl[11] = '{16'h00AF, 1'b0, 4'd0, 4'd1, 4'd0, 4'd9,   8'sd10, 1'b0, 1'b0};
        tbl[12] = '{16'h8000, 1'b0, 4'd0, 4'd1, 4'd0, 4'd9,   8'sd10, 1'b1, 1'b0};
        tbl[13] = '{16'h0F00, 1'b0, 4'd0, 4'd1, 4'd0, 4'd9,   8'sd10, 1'b1, 1'b0};
        tbl[14] = '{16'h0648, 1'b0, 4'd1, 4'd0, 4'd0, 4'd5,  8'sd100, 1'b0, 1'b1};

        raw_data  = 16'h0000;
        raw_valid = 1'b0;
        rst_n     = 1'b0;
        idle(3);
        check("reset_outputs", 32'(actual()), 32'd0);
        check("reset_busy_fmt", {30'd0, busy, fmt_valid}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        // Table-driven vectors.
        for (int i = 0; i < 15; i++) begin
            send(tbl[i].raw, pack_vec(tbl[i]));
        end

        // Second edge during busy: one pulse, first code's result only.
        base = fmt_cnt;
        @(negedge clk);
        raw_data  = 16'h0191;
        raw_valid = 1'b1;
        exp_q.push_back(pack(1'b0, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0, 8'sd25, 1'b0));
        idle(4);
        raw_valid = 1'b0;
        idle(3);
        raw_data  = 16'h0320;
        raw_valid = 1'b1;
        idle(3);
        raw_valid = 1'b0;
        idle(30);
        check("busy_drop_pulses", 32'(fmt_cnt - base), 32'd1);
        check("busy_drop_queue", 32'(exp_q.size()), 32'd0);

        // Reset during the third CONV cycle with raw_valid held high.
        @(negedge clk);
        raw_data  = 16'h0648;
        raw_valid = 1'b1;
        for (int i = 0; i < 6; i++) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        check("midreset_outputs", 32'(actual()), 32'd0);
        check("midreset_busy_fmt", {30'd0, busy, fmt_valid}, 32'd0);
        base = fmt_cnt;
        rst_n = 1'b1;
        idle(30);
        check("held_high_no_edge", 32'(fmt_cnt - base), 32'd0);
        check("held_high_busy", 32'(busy), 32'd0);
        raw_valid = 1'b0;
        idle(4);
        send(16'h02E0, pack(1'b0, 1'b0, 4'd0, 4'd4, 4'd6, 4'd0, 8'sd46, 1'b0));

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ds18b20_temp_fmt.md
# ds18b20_temp_fmt

Downstream consumer of the DS18B20Z one-wire driver: captures each completed 16-bit temperature code (12-bit, 1/16 °C LSB, two's complement) and converts it into sign, three BCD integer digits and one BCD tenths digit for the segment display. It also provides a signed integer temperature, a range-error flag and an optional over-temperature alarm with hysteresis. Runs on the system clock; conversion is a serial double-dabble so no wide dividers are inferred.

## Interface
- ALARM_HI, 8'sd50, alarm set threshold in whole °C, signed; used only with the alarm feature.
- ALARM_LO, 8'sd45, alarm clear threshold in whole °C, signed; must be < ALARM_HI.
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous active-low reset.
- raw_data  in  16  driver data_out; stable while raw_valid is high.
- raw_valid  in  1  driver data_out_en; level produced in the driver's 1 MHz domain.
- temp_sign  out  1  1 means negative; reset 0.
- temp_bcd_h, temp_bcd_t, temp_bcd_o  out  4 each  hundreds, tens and ones digits of the magnitude; reset 0.
- temp_frac  out  4  tenths digit, truncated; reset 0.
- temp_int  out  8 signed  integer °C, truncated toward zero; reset 0.
- fmt_valid  out  1  one-cycle pulse when the outputs update; reset 0.
- busy  out  1  high from capture until the fmt_valid cycle; reset 0.
- range_err  out  1  the last code was outside the range −55.0…+125.0 °C; reset 0.
- alarm  out  1  over-temperature with hysteresis; reset 0; present only with TEMP_ALARM_EN.

## Operation
- raw_valid passes through a 2-FF synchronizer, then a third flop for edge detection. Only a rising edge starts work.
- FSM states and transitions:
  - IDLE: on a rising edge, latch raw_data into cap and go to ABS.
  - ABS:
    - sign = cap[15].
    - mag = sign ? (~cap + 1) : cap, 16-bit.
    - int7 = mag[10:4].
    - frac = (mag[3:0] × 10) >> 4, in range 0–9.
    - range_err_n = (mag[15:11] != 0) | (!sign & mag > 16'h07D0) | (sign & mag > 16'h0370).
    - Go to CONV.
  - CONV: double-dabble on int7, one bit per cycle, MSB first, 7 cycles. Each cycle adds 3 to any BCD nibble ≥5, then shifts. Go to DONE.
  - DONE: register all outputs, pulse fmt_valid, go to IDLE.
- When range_err_n = 1:
  - range_err is set to 1 and fmt_valid still pulses.
  - Digits, temp_sign and temp_int hold their previous values.
  - alarm is not evaluated.
- When range_err_n = 0:
  - range_err is cleared and all outputs update.
  - temp_int = sign ? −int7 : int7.
- A negative value with zero integer part (e.g. −0.5) gives temp_sign=1, temp_int=0.
- Rising edges that arrive while busy are ignored. They are not queued.
- Reset at any point returns to IDLE with every output at its reset value. The synchronizer flops clear, so a raw_valid level that is high at reset release does not produce an edge.

## Timing
- Let edge k be the first clk_in edge that samples raw_valid high.
- Capture occurs at k+2; busy rises after k+2.
- ABS runs at k+3, CONV at k+4…k+10, DONE at k+11.
- Outputs and fmt_valid are valid in the cycle after k+11. fmt_valid and the busy fall are coincident.
- Fixed latency: 12 clk_in cycles.
- The upstream update period is ≥750 ms, so dropping edges never occurs in normal operation.

## Configuration
- TEMP_ALARM_EN defined:
  - alarm port and logic are present.
  - On a valid update, alarm is set if temp_int ≥ ALARM_HI.
  - alarm is cleared if temp_int < ALARM_LO; otherwise it holds.
- TEMP_ALARM_EN undefined: the port and logic are absent, and all other behaviour is identical.

## Structure
- Shared package ds18b20_pkg holds:
  - FSM state encodings (IDLE, ABS, CONV, DONE).
  - Limit constants TEMP_MAX_CODE = 16'h07D0 and TEMP_MIN_MAG = 16'h0370.
  - Conversion length CONV_BITS = 7.
- One sub-module: ds18b20_bcd_serial (start, 7-bit in, done, 12-bit BCD out). It is reusable for other display paths.

## Test plan
- raw 16'h0191 → sign 0, digits 0/2/5, frac 0, temp_int 25, range_err 0, fmt_valid exactly 12 cycles after first raw_valid sample.
- raw 16'hFF5E → sign 1, digits 0/1/0, frac 1, temp_int −10; then 16'h07D0 → 1/2/5, frac 0, temp_int 125.
- raw 16'hFC90 → sign 1, digits 0/5/5, range_err 0; then 16'h0800 → range_err 1, digits still 1/2/5 from a prior 125.0.
- TEMP_ALARM_EN: 16'h0320 (50.0) → alarm 1; 16'h02E0 (46.0) → alarm 1; 16'h02C0 (44.0) → alarm 0.
- Second raw_valid edge with a different code during busy → single fmt_valid, outputs from the first code only.
- rst_n_in low at CONV cycle 3 → all outputs 0, busy 0. With raw_valid held high through release, no fmt_valid occurs until raw_valid toggles.
